// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-RAM port arbiter: FSM state and port-owner encodings.
// No logic here.
// Nothing to stall.
package dmem_port_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  // Width needed to hold 0..limit inclusive.
  function automatic int starve_cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_starve_ctr.sv
// Saturating starvation counter for the debug port; 'starved' once LIMIT is reached.
// Count updates on the clock edge; o_starved is a registered-count compare.
// No backpressure; clear has priority over increment.
// Ports: clk, rst (async, active-high), i_clr, i_inc, o_starved.
module dmem_starve_ctr
  import dmem_port_arbiter_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_starved
);

  localparam int CW = starve_cnt_w(LIMIT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt < CW'(LIMIT))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_starved = (r_cnt >= CW'(LIMIT));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data RAM between the cpu MEM stage and the debug/loader port.
// Issue cycle N (ram_* driven), ack at N+1; next issue no earlier than N+2.
// Requesters hold req until ack; cpu_stall = cpu_req & ~cpu_ack. Cpu has priority,
// except dbg is forced to win after STARVE_LIMIT consecutive lost cycles.
// Ports: clk, rst; cpu_{req,we,addr,wdata,rdata,ack,stall}; dbg_{req,we,addr,wdata,rdata,ack};
//        ram_{we,addr,din} to the RAM, ram_dout (1-cycle synchronous read) from it.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_e r_state;
  state_e w_state_nxt;
  owner_e r_owner;
  owner_e w_owner_nxt;
  owner_e w_win;
  logic   w_issue;
  logic   w_starved;
  logic   w_dbg_issued;

  // Byte-lane and out-of-range address bits are intentionally dropped (addresses wrap).
  logic   w_unused_addr_bits;
  assign w_unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                                dbg_addr[31:ADDR_W+2], dbg_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_CPU;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_win       = OWN_CPU;
    w_issue     = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_din     = '0;
    cpu_ack     = 1'b0;
    cpu_rdata   = '0;
    dbg_ack     = 1'b0;
    dbg_rdata   = '0;
    // Registers are already cleared asynchronously, but the IDLE arbitration is
    // combinational from the request inputs, so it must be masked while rst is high.
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          if (dbg_req && w_starved) begin
            w_win   = OWN_DBG;
            w_issue = 1'b1;
          end else if (cpu_req) begin
            w_win   = OWN_CPU;
            w_issue = 1'b1;
          end else if (dbg_req) begin
            w_win   = OWN_DBG;
            w_issue = 1'b1;
          end
          if (w_issue) begin
            if (w_win == OWN_DBG) begin
              ram_we   = dbg_we;
              ram_addr = dbg_addr[ADDR_W+1:2];
              ram_din  = dbg_wdata;
            end else begin
              ram_we   = cpu_we;
              ram_addr = cpu_addr[ADDR_W+1:2];
              ram_din  = cpu_wdata;
            end
            w_state_nxt = ST_BUSY;
            w_owner_nxt = w_win;
          end
        end
        ST_BUSY: begin
          // Writes ack too; rdata is then whatever the RAM returned and is ignored.
          if (r_owner == OWN_DBG) begin
            dbg_ack   = 1'b1;
            dbg_rdata = ram_dout;
          end else begin
            cpu_ack   = 1'b1;
            cpu_rdata = ram_dout;
          end
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign cpu_stall    = cpu_req & ~cpu_ack;
  assign w_dbg_issued = w_issue && (w_win == OWN_DBG);

  // Counts every cycle dbg waits, including the BUSY cycle of any access.
  dmem_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (~dbg_req | w_dbg_issued),
    .i_inc    (dbg_req & ~w_dbg_issued),
    .o_starved(w_starved)
  );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter with a behavioural synchronous RAM.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// Expected read data is queued per port and popped by a monitor on each ack.
module tb_dmem_port_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic        chk;
    logic [31:0] dat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_we;
  logic [31:0]       cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              cpu_ack, cpu_stall;
  logic              dbg_req, dbg_we;
  logic [31:0]       dbg_addr;
  logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
  logic              dbg_ack;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din, ram_dout;

  int checks   = 0;
  int failures = 0;
  int we_cnt   = 0;

  exp_t cpu_q[$];
  exp_t dbg_q[$];
  exp_t e_cpu, e_dbg;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic              bd_we;
  logic [ADDR_W-1:0] bd_addr;
  logic [31:0]       bd_dat;

  always #5 clk = ~clk;

  dmem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Single-port RAM with a backdoor preload path.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_dat;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected response whenever a port acks.
  always @(negedge clk) begin
    if (ram_we) we_cnt++;
    if (cpu_ack && dbg_ack) check("both_acks", 32'd1, 32'd0);
    if (cpu_ack) begin
      check("cpu_ack_expected", 32'(cpu_q.size() != 0), 32'd1);
      if (cpu_q.size() != 0) begin
        e_cpu = cpu_q.pop_front();
        if (e_cpu.chk) check("cpu_rdata", cpu_rdata, e_cpu.dat);
      end
    end else begin
      check("cpu_rdata_zero_no_ack", cpu_rdata, 32'd0);
    end
    if (dbg_ack) begin
      check("dbg_ack_expected", 32'(dbg_q.size() != 0), 32'd1);
      if (dbg_q.size() != 0) begin
        e_dbg = dbg_q.pop_front();
        if (e_dbg.chk) check("dbg_rdata", dbg_rdata, e_dbg.dat);
      end
    end else begin
      check("dbg_rdata_zero_no_ack", dbg_rdata, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full access on one port: present request, wait (bounded) for ack, release.
  task automatic op(input bit is_dbg, input logic we, input logic [31:0] addr,
                    input logic [31:0] wd, input logic [31:0] exp_rd);
    bit got;
    if (is_dbg) begin
      dbg_q.push_back('{~we, exp_rd});
      dbg_we = we; dbg_addr = addr; dbg_wdata = wd; dbg_req = 1'b1;
    end else begin
      cpu_q.push_back('{~we, exp_rd});
      cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = is_dbg ? dbg_ack : cpu_ack;
    end
    check(is_dbg ? "dbg_ack_timeout" : "cpu_ack_timeout", 32'(got), 32'd1);
    tick();
    if (is_dbg) dbg_req = 1'b0;
    else        cpu_req = 1'b0;
  endtask

  logic [ADDR_W-1:0] t4_exp [12] = '{14'h10, 14'h0, 14'h10, 14'h0, 14'h11, 14'h0,
                                     14'h10, 14'h0, 14'h10, 14'h0, 14'h11, 14'h0};

  initial begin
    #100000;
    $display("FAIL global_timeout t=%0t", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    bd_we = 1'b1; bd_addr = 14'h10; bd_dat = 32'hDEADBEEF;
    tick();
    bd_we = 1'b0;
    @(negedge clk);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    check("rst_dbg_ack", 32'(dbg_ack), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("idle_ram_addr", 32'(ram_addr), 32'd0);
    check("idle_ram_din", ram_din, 32'd0);
    tick();

    // T1 cpu load
    cpu_q.push_back('{1'b1, 32'hDEADBEEF});
    cpu_we = 1'b0; cpu_addr = 32'h40; cpu_req = 1'b1;
    @(negedge clk);
    check("t1_ram_addr", 32'(ram_addr), 32'h10);
    check("t1_ram_we", 32'(ram_we), 32'd0);
    check("t1_stall_issue", 32'(cpu_stall), 32'd1);
    @(negedge clk);
    check("t1_ack", 32'(cpu_ack), 32'd1);
    check("t1_stall_ack", 32'(cpu_stall), 32'd0);
    tick();
    cpu_req = 1'b0;
    tick();

    // T2 cpu store then load
    op(1'b0, 1'b1, 32'h44, 32'h12345678, 32'h0);
    check("t2_we_pulses", 32'(we_cnt), 32'd1);
    check("t2_mem", mem[14'h11], 32'h12345678);
    op(1'b0, 1'b0, 32'h44, 32'h0, 32'h12345678);
    tick();

    // T3 simultaneous requests
    cpu_q.push_back('{1'b1, 32'hDEADBEEF});
    dbg_q.push_back('{1'b1, 32'h12345678});
    cpu_we = 1'b0; cpu_addr = 32'h40; cpu_req = 1'b1;
    dbg_we = 1'b0; dbg_addr = 32'h44; dbg_req = 1'b1;
    @(negedge clk);
    check("t3_issue_cpu", 32'(ram_addr), 32'h10);
    @(negedge clk);
    check("t3_cpu_ack", 32'(cpu_ack), 32'd1);
    check("t3_dbg_ack_early", 32'(dbg_ack), 32'd0);
    tick();
    cpu_req = 1'b0;
    @(negedge clk);
    check("t3_issue_dbg", 32'(ram_addr), 32'h11);
    check("t3_dbg_ack_n2", 32'(dbg_ack), 32'd0);
    @(negedge clk);
    check("t3_dbg_ack", 32'(dbg_ack), 32'd1);
    tick();
    dbg_req = 1'b0;
    tick();
    tick();

    // T4 starvation guard: cpu, cpu, dbg repeating every 6 cycles
    for (int i = 0; i < 4; i++) cpu_q.push_back('{1'b1, 32'hDEADBEEF});
    for (int i = 0; i < 2; i++) dbg_q.push_back('{1'b1, 32'h12345678});
    cpu_we = 1'b0; cpu_addr = 32'h40; cpu_req = 1'b1;
    dbg_we = 1'b0; dbg_addr = 32'h44; dbg_req = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("t4_addr_c%0d", c), 32'(ram_addr), 32'(t4_exp[c]));
    end
    tick();
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick();
    tick();

    // T5 reset during BUSY of a cpu load: no ack, outputs zero at once
    cpu_we = 1'b0; cpu_addr = 32'h40; cpu_req = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    check("t5_ack_async", 32'(cpu_ack), 32'd0);
    check("t5_rdata_async", cpu_rdata, 32'd0);
    check("t5_stall_follows_req", 32'(cpu_stall), 32'd1);
    @(negedge clk);
    check("t5_ram_addr_rst", 32'(ram_addr), 32'd0);
    check("t5_ram_we_rst", 32'(ram_we), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    op(1'b0, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF);
    tick();

    // T6 dbg write with address wrap
    dbg_q.push_back('{1'b0, 32'h0});
    dbg_we = 1'b1; dbg_addr = 32'h0001_0004; dbg_wdata = 32'hA5A5_0001; dbg_req = 1'b1;
    @(negedge clk);
    check("t6_ram_addr", 32'(ram_addr), 32'h1);
    check("t6_ram_we", 32'(ram_we), 32'd1);
    check("t6_ram_din", ram_din, 32'hA5A5_0001);
    @(negedge clk);
    check("t6_ack", 32'(dbg_ack), 32'd1);
    tick();
    dbg_req = 1'b0;
    check("t6_mem", mem[14'h1], 32'hA5A5_0001);
    op(1'b1, 1'b0, 32'h4, 32'h0, 32'hA5A5_0001);
    tick();
    tick();

    check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    check("dbg_q_drained", 32'(dbg_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
